// File: rtl/fir_requant_pkg.sv
// fir_requant_pkg: constants shared by the FIR output requantiser.
//   SHIFT_W     - width of the right-shift amount (shifts 0..31)
//   DOUT16_MAX  - largest value of a 16-bit two's complement output sample
//   DOUT16_MIN  - smallest value of a 16-bit two's complement output sample
package fir_requant_pkg;

  localparam int SHIFT_W = 5;

  localparam logic signed [15:0] DOUT16_MAX = 16'sh7FFF;
  localparam logic signed [15:0] DOUT16_MIN = 16'sh8000;

endpackage

// File: rtl/fir_requant_sat.sv
// fir_requant_sat: combinational clamp of a rounded DIN_W+1 bit value into
// the DOUT_W bit two's complement range.
//   din  - rounded/shifted sample, signed, DIN_W+1 bits
//   dout - clamped sample, DOUT_W bits
//   sat  - 1 when din lay outside the output range and was clamped
module fir_requant_sat
  import fir_requant_pkg::*;
#(
  parameter int DIN_W  = 32,
  parameter int DOUT_W = 16
) (
  input  logic signed [DIN_W:0]    din,
  output logic        [DOUT_W-1:0] dout,
  output logic                     sat
);

  logic signed [DIN_W:0] max_v;
  logic signed [DIN_W:0] min_v;

  // The common 16-bit output takes its bounds from the package; other
  // widths build them from the parameter.
  if (DOUT_W == 16) begin : g_bounds_pkg
    assign max_v = (DIN_W+1)'(DOUT16_MAX);
    assign min_v = (DIN_W+1)'(DOUT16_MIN);
  end else begin : g_bounds_gen
    assign max_v = {{(DIN_W+2-DOUT_W){1'b0}}, {(DOUT_W-1){1'b1}}};
    assign min_v = {{(DIN_W+2-DOUT_W){1'b1}}, {(DOUT_W-1){1'b0}}};
  end

  always_comb begin
    dout = din[DOUT_W-1:0];
    sat  = 1'b0;
    if (din > max_v) begin
      dout = max_v[DOUT_W-1:0];
      sat  = 1'b1;
    end else if (din < min_v) begin
      dout = min_v[DOUT_W-1:0];
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/fir_requant.sv
// fir_requant: requantises an AXI-Stream of wide FIR results to DOUT_W bits.
// Stage 1 rounds half-up and arithmetic-shifts right by a per-frame shift;
// stage 2 saturates and holds the output registers.
//   aclk, aresetn          - clock, asynchronous active-low reset
//   s_axis_data_*          - input stream (tdata DIN_W, tvalid, tlast, tready)
//   m_axis_data_*          - output stream (tdata DOUT_W, tvalid, tlast,
//                            tuser = saturation flag, tready)
//   cfg_shift              - shift amount, sampled on the first beat of a frame
//   sat_clr, sat_cnt       - saturation counter clear / value; these ports
//                            exist only when FIR_REQUANT_SAT_CNT_EN is defined
// Handshake: a beat moves on a side only at a rising edge where tvalid and
// tready are both high; a stage advances when the next stage is empty or is
// emptied in the same cycle, so bubbles collapse.
module fir_requant
  import fir_requant_pkg::*;
#(
  parameter int DIN_W  = 32,
  parameter int DOUT_W = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [DIN_W-1:0]     s_axis_data_tdata,
  input  logic                 s_axis_data_tvalid,
  input  logic                 s_axis_data_tlast,
  output logic                 s_axis_data_tready,
  output logic [DOUT_W-1:0]    m_axis_data_tdata,
  output logic                 m_axis_data_tvalid,
  output logic                 m_axis_data_tlast,
  output logic                 m_axis_data_tuser,
  input  logic                 m_axis_data_tready,
  input  logic [SHIFT_W-1:0]   cfg_shift
`ifdef FIR_REQUANT_SAT_CNT_EN
  ,
  input  logic                 sat_clr,
  output logic [15:0]          sat_cnt
`endif
);

  // Stage 1 registers
  logic                  v1_q, v1_d;
  logic signed [DIN_W:0] s1_data_q, s1_data_d;
  logic                  s1_last_q, s1_last_d;
  // Stage 2 / output registers
  logic                  v2_q, v2_d;
  logic [DOUT_W-1:0]     m_data_q, m_data_d;
  logic                  m_last_q, m_last_d;
  logic                  m_user_q, m_user_d;
  // Frame tracking
  logic [SHIFT_W-1:0]    shift_q, shift_d;
  logic                  frame_start_q, frame_start_d;
  // Holds tready low during reset and opens it on the first edge after.
  logic                  ready_en_q, ready_en_d;

  logic                  in_take, adv2, out_take;
  logic [SHIFT_W-1:0]    eff_shift;
  logic signed [DIN_W:0] x_ext, half, rnd_sum, rnd_res;
  logic [DOUT_W-1:0]     sat_data;
  logic                  sat_flag;

  assign s_axis_data_tready = ready_en_q && (!v1_q || !v2_q || m_axis_data_tready);
  assign in_take  = s_axis_data_tvalid && s_axis_data_tready;
  assign adv2     = v1_q && (!v2_q || m_axis_data_tready);
  assign out_take = v2_q && m_axis_data_tready;

  assign m_axis_data_tdata  = m_data_q;
  assign m_axis_data_tvalid = v2_q;
  assign m_axis_data_tlast  = m_last_q;
  assign m_axis_data_tuser  = m_user_q;

  // The first beat of a frame uses the live cfg_shift; later beats use the
  // value latched from that first beat.
  assign eff_shift = frame_start_q ? cfg_shift : shift_q;
  assign x_ext     = $signed({s_axis_data_tdata[DIN_W-1], s_axis_data_tdata});

  // Half-up rounding: add half an LSB of the result before the shift.
  // The extra bit keeps the add from overflowing for the largest input.
  always_comb begin
    half = '0;
    if (eff_shift != '0) begin
      half = (DIN_W+1)'(1) << (eff_shift - SHIFT_W'(1));
    end
    rnd_sum = x_ext + half;
    rnd_res = rnd_sum >>> eff_shift;
  end

  fir_requant_sat #(
    .DIN_W  (DIN_W),
    .DOUT_W (DOUT_W)
  ) u_sat (
    .din  (s1_data_q),
    .dout (sat_data),
    .sat  (sat_flag)
  );

  always_comb begin
    v1_d          = v1_q;
    s1_data_d     = s1_data_q;
    s1_last_d     = s1_last_q;
    v2_d          = v2_q;
    m_data_d      = m_data_q;
    m_last_d      = m_last_q;
    m_user_d      = m_user_q;
    shift_d       = shift_q;
    frame_start_d = frame_start_q;
    ready_en_d    = 1'b1;

    if (in_take) begin
      v1_d          = 1'b1;
      s1_data_d     = rnd_res;
      s1_last_d     = s_axis_data_tlast;
      shift_d       = eff_shift;
      frame_start_d = s_axis_data_tlast;
    end else if (adv2) begin
      v1_d = 1'b0;
    end

    // Output payload changes only when a new beat moves in, so it is
    // stable while the downstream stalls.
    if (adv2) begin
      v2_d     = 1'b1;
      m_data_d = sat_data;
      m_last_d = s1_last_q;
      m_user_d = sat_flag;
    end else if (out_take) begin
      v2_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      v1_q          <= 1'b0;
      s1_data_q     <= '0;
      s1_last_q     <= 1'b0;
      v2_q          <= 1'b0;
      m_data_q      <= '0;
      m_last_q      <= 1'b0;
      m_user_q      <= 1'b0;
      shift_q       <= '0;
      frame_start_q <= 1'b1;
      ready_en_q    <= 1'b0;
    end else begin
      v1_q          <= v1_d;
      s1_data_q     <= s1_data_d;
      s1_last_q     <= s1_last_d;
      v2_q          <= v2_d;
      m_data_q      <= m_data_d;
      m_last_q      <= m_last_d;
      m_user_q      <= m_user_d;
      shift_q       <= shift_d;
      frame_start_q <= frame_start_d;
      ready_en_q    <= ready_en_d;
    end
  end

`ifdef FIR_REQUANT_SAT_CNT_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;

  // Counts delivered saturated beats; sticks at all-ones, clear has priority.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (sat_clr) begin
      sat_cnt_d = '0;
    end else if (out_take && m_user_q && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_d = sat_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_fir_requant.sv
module tb_fir_requant;

  logic        aclk;
  logic        aresetn;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_user;
  logic        m_ready;
  logic [4:0]  cfg_shift;
`ifdef FIR_REQUANT_SAT_CNT_EN
  logic        sat_clr;
  logic [15:0] sat_cnt;
`endif

  int          checks   = 0;
  int          failures = 0;
  logic [17:0] exp_q[$];
  bit          mdl_frame_start;
  int          mdl_shift;
  bit          hold_pending;
  logic [17:0] hold_val;
  int          acc_cnt;
  int          out_cnt;
  int          last_seen_at;
  bit          rand_ready;

  fir_requant #(
    .DIN_W  (32),
    .DOUT_W (16)
  ) dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .s_axis_data_tdata  (s_data),
    .s_axis_data_tvalid (s_valid),
    .s_axis_data_tlast  (s_last),
    .s_axis_data_tready (s_ready),
    .m_axis_data_tdata  (m_data),
    .m_axis_data_tvalid (m_valid),
    .m_axis_data_tlast  (m_last),
    .m_axis_data_tuser  (m_user),
    .m_axis_data_tready (m_ready),
    .cfg_shift          (cfg_shift)
`ifdef FIR_REQUANT_SAT_CNT_EN
    ,
    .sat_clr            (sat_clr),
    .sat_cnt            (sat_cnt)
`endif
  );

  // Clock
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: round half-up = floor((x + 2^(s-1)) / 2^s), then clamp to int16.
  function automatic logic [17:0] ref_out(input logic [31:0] x, input int s, input logic last);
    longint v, d, n, q;
    logic sat;
    logic [15:0] o;
    v = longint'($signed(x));
    if (s == 0) begin
      q = v;
    end else begin
      d = longint'(1) << s;
      n = v + d / 2;
      q = n / d;
      if ((n % d != 0) && (n < 0)) q = q - 1;
    end
    sat = 1'b0;
    if (q > 32767) begin
      q = 32767; sat = 1'b1;
    end else if (q < -32768) begin
      q = -32768; sat = 1'b1;
    end
    o = 16'(q);
    return {sat, last, o};
  endfunction

  function automatic logic [31:0] gen_data();
    logic [31:0] d;
    d = $urandom;
    if ($urandom_range(0, 1) == 1) d = {{16{d[15]}}, d[15:0]};
    return d;
  endfunction

  // One clock: observe transfers just before the edge, then move to the
  // next falling edge where the caller drives new inputs.
  task automatic tick();
    logic [17:0] got, exp;
    #1;
    if (aresetn) begin
      got = {m_user, m_last, m_data};
      if (hold_pending) begin
        chk("hold_valid", 64'(m_valid), 64'(1));
        chk("hold_payload", 64'(got), 64'(hold_val));
        hold_pending = 0;
      end
      if (m_valid && m_ready) begin
        out_cnt++;
        chk("out_expected", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          exp = exp_q.pop_front();
          chk("out_data", 64'(got[15:0]), 64'(exp[15:0]));
          chk("out_last", 64'(got[16]), 64'(exp[16]));
          chk("out_user", 64'(got[17]), 64'(exp[17]));
        end
        if (m_last) last_seen_at = out_cnt;
      end
      if (m_valid && !m_ready) begin
        hold_pending = 1;
        hold_val     = got;
      end
      if (s_valid && s_ready) begin
        acc_cnt++;
        if (mdl_frame_start) mdl_shift = int'(cfg_shift);
        exp_q.push_back(ref_out(s_data, mdl_shift, s_last));
        mdl_frame_start = s_last;
      end
    end
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic send_one(input logic [31:0] x, input logic last);
    int a0;
    bit done;
    a0 = acc_cnt;
    done = 0;
    s_valid = 1; s_data = x; s_last = last;
    for (int i = 0; i < 64 && !done; i++) begin
      if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
      tick();
      done = (acc_cnt != a0);
    end
    s_valid = 0;
    chk("send_accept", 64'(done), 64'(1));
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!m_valid && n < 20) begin
      tick();
      n++;
    end
    chk("out_arrive", 64'(m_valid), 64'(1));
  endtask

  task automatic drain();
    s_valid = 0;
    rand_ready = 0;
    m_ready = 1;
    for (int i = 0; i < 50 && (exp_q.size() > 0 || m_valid); i++) tick();
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    int a0;
    int base;
    bit pend;
    logic [31:0] x29 [3];
    logic [15:0] e29 [3];
    logic        u29 [3];

    aresetn = 0; s_valid = 0; s_data = '0; s_last = 0; m_ready = 1; cfg_shift = '0;
`ifdef FIR_REQUANT_SAT_CNT_EN
    sat_clr = 0;
`endif
    mdl_frame_start = 1; mdl_shift = 0; hold_pending = 0;
    acc_cnt = 0; out_cnt = 0; last_seen_at = 0; rand_ready = 0;

    // Reset state
    repeat (2) @(negedge aclk);
    chk("rst_m_valid", 64'(m_valid), 64'(0));
    chk("rst_m_data", 64'(m_data), 64'(0));
    chk("rst_m_last", 64'(m_last), 64'(0));
    chk("rst_m_user", 64'(m_user), 64'(0));
    chk("rst_s_ready", 64'(s_ready), 64'(0));
`ifdef FIR_REQUANT_SAT_CNT_EN
    chk("rst_sat_cnt", 64'(sat_cnt), 64'(0));
`endif
    aresetn = 1;
    tick();
    chk("post_rst_s_ready", 64'(s_ready), 64'(1));

    // Basic rounding and two-cycle latency
    cfg_shift = 5'd15;
    s_valid = 1; s_data = 32'h0000_4000; s_last = 1;
    a0 = acc_cnt;
    tick();
    s_valid = 0;
    chk("lat_accept", 64'(acc_cnt - a0), 64'(1));
    chk("lat_cycle1_valid", 64'(m_valid), 64'(0));
    tick();
    chk("lat_cycle2_valid", 64'(m_valid), 64'(1));
    chk("lat_data", 64'(m_data), 64'h0001);
    chk("lat_user", 64'(m_user), 64'(0));
    tick();

    // Saturation boundaries
    x29[0] = 32'h3FFF_FFFF; e29[0] = 16'h7FFF; u29[0] = 1;
    x29[1] = 32'h8000_0000; e29[1] = 16'h8000; u29[1] = 1;
    x29[2] = 32'hFFFF_C000; e29[2] = 16'h0000; u29[2] = 0;
    for (int i = 0; i < 3; i++) begin
      send_one(x29[i], 1'b1);
      wait_out();
      chk("sat_dir_data", 64'(m_data), 64'(e29[i]));
      chk("sat_dir_user", 64'(m_user), 64'(u29[i]));
      tick();
    end
    drain();

    // Backpressure: downstream stalled for 5 cycles
    m_ready = 0;
    s_valid = 1; s_last = 0; s_data = gen_data();
    a0 = acc_cnt;
    for (int i = 0; i < 5; i++) begin
      base = acc_cnt;
      tick();
      if (acc_cnt != base) s_data = gen_data();
    end
    chk("stall_accepts", 64'(acc_cnt - a0), 64'(2));
    chk("stall_s_ready", 64'(s_ready), 64'(0));
    m_ready = 1;
    for (int i = 0; i < 10; i++) begin
      base = acc_cnt;
      tick();
      if (acc_cnt != base) s_data = gen_data();
    end
    send_one(gen_data(), 1'b1);
    drain();

    // Random traffic with mid-frame shift changes
    pend = 0;
    for (int i = 0; i < 400; i++) begin
      if (!pend) begin
        s_valid = ($urandom_range(0, 2) != 0);
        s_data  = gen_data();
        s_last  = ($urandom_range(0, 7) == 0);
      end
      m_ready   = ($urandom_range(0, 3) != 0);
      cfg_shift = 5'($urandom_range(0, 31));
      a0 = acc_cnt;
      tick();
      pend = s_valid && (acc_cnt == a0);
    end
    s_valid = 0;
    send_one(gen_data(), 1'b1);
    drain();

    // 1000-sample frame, shift request changed halfway, then next frame
    cfg_shift = 5'd15;
    rand_ready = 1;
    base = out_cnt;
    for (int i = 0; i < 1000; i++) begin
      if (i == 500) cfg_shift = 5'd8;
      send_one(gen_data(), (i == 999));
    end
    drain();
    chk("frame_last_pos", 64'(last_seen_at - base), 64'(1000));
    chk("frame_out_count", 64'(out_cnt - base), 64'(1000));
    rand_ready = 1;
    for (int i = 0; i < 20; i++) send_one(gen_data(), (i == 19));
    drain();
    send_one(32'h0000_0080, 1'b1);
    wait_out();
    chk("next_frame_shift8", 64'(m_data), 64'h0001);
    tick();

    // Reset mid-frame with two beats in flight
    cfg_shift = 5'd3;
    m_ready = 0;
    send_one(gen_data(), 1'b0);
    send_one(gen_data(), 1'b0);
    #2;
    aresetn = 0;
    #1;
    chk("midrst_m_valid", 64'(m_valid), 64'(0));
    chk("midrst_s_ready", 64'(s_ready), 64'(0));
    exp_q.delete();
    mdl_frame_start = 1; mdl_shift = 0; hold_pending = 0;
    @(negedge aclk);
    aresetn = 1;
    m_ready = 1;
    for (int i = 0; i < 5; i++) tick();
    chk("midrst_no_stale", 64'(m_valid), 64'(0));
    cfg_shift = 5'd10;
    send_one(32'h0000_0C00, 1'b1);
    wait_out();
    chk("midrst_new_frame", 64'(m_data), 64'h0003);
    tick();
    drain();

`ifdef FIR_REQUANT_SAT_CNT_EN
    // Saturation counter
    sat_clr = 1;
    tick();
    sat_clr = 0;
    chk("satcnt_clr", 64'(sat_cnt), 64'(0));
    cfg_shift = 5'd0;
    for (int i = 0; i < 3; i++) send_one(32'h7FFF_FFFF, 1'b1);
    send_one(32'h0000_0005, 1'b1);
    drain();
    chk("satcnt_three", 64'(sat_cnt), 64'(3));
    m_ready = 0;
    send_one(32'h8000_0000, 1'b1);
    wait_out();
    chk("satcnt_pending_user", 64'(m_user), 64'(1));
    m_ready = 1;
    sat_clr = 1;
    tick();
    sat_clr = 0;
    chk("satcnt_clr_wins", 64'(sat_cnt), 64'(0));
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
